frame_capture: RTL and testbench

FRAME_CAPTURE -- requirements
Module: frame_capture

---
 rtl/frame_capture.sv | 129 ++++++++++++
 tb/tb_frame_capture.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_capture.sv
// Pixel stream to frame-buffer writer with one registered write stage and frame status.
// Define FRAME_CAPTURE_CHECK_EN to build the sticky geometry checker behind error_flag.
module frame_capture (
   input  logic        clk,
   input  logic        reset,
   input  logic [12:0] image_width,
   input  logic [12:0] image_height,
   input  logic        valid_data_in,
   input  logic        sof,
   input  logic        last_x,
   input  logic [7:0]  r,
   input  logic [7:0]  g,
   input  logic [7:0]  b,
   output logic        ready_out,
   input  logic        mem_ready,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        frame_done,
   output logic        error_flag,
   output logic [15:0] frame_count
);

   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] CAPTURE = 1'b1;

   logic [0:0]  state;
   logic [12:0] x;
   logic [12:0] y;
   logic [12:0] height_r;
   logic [31:0] pix_idx;
   logic        accept;
   logic        take;
   logic [12:0] eff_x;
   logic [12:0] eff_y;
   logic [12:0] eff_h;
   logic [31:0] eff_idx;
   logic        frame_end;

   // A new write may be loaded only when the output register is empty or draining this cycle.
   assign ready_out = mem_ready || !wr_en;
   assign accept    = valid_data_in && ready_out;
   assign take      = accept && (sof || (state == CAPTURE));

   // sof restarts position first so a sof+last_x beat is a one-pixel line.
   always_comb begin
      eff_x     = sof ? 13'd0 : x;
      eff_y     = sof ? 13'd0 : y;
      eff_h     = sof ? image_height : height_r;
      eff_idx   = sof ? 32'd0 : pix_idx;
      frame_end = last_x && (eff_y == (eff_h - 13'd1));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         x           <= 13'd0;
         y           <= 13'd0;
         height_r    <= 13'd0;
         pix_idx     <= 32'd0;
         frame_count <= 16'd0;
      end else if (take) begin
         if (sof) begin
            height_r <= image_height;
         end
         pix_idx <= eff_idx + 32'd1;
         if (last_x) begin
            x <= 13'd0;
            y <= eff_y + 13'd1;
         end else begin
            x <= eff_x + 13'd1;
            y <= eff_y;
         end
         if (frame_end) begin
            state       <= IDLE;
            frame_count <= frame_count + 16'd1;
         end else begin
            state <= CAPTURE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_en      <= 1'b0;
         wr_addr    <= 32'd0;
         wr_data    <= 32'd0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= take && frame_end;
         if (take) begin
            wr_en   <= 1'b1;
            wr_addr <= eff_idx;
            wr_data <= {8'h00, r, g, b};
         end else if (mem_ready) begin
            wr_en <= 1'b0;
         end
      end
   end

`ifdef FRAME_CAPTURE_CHECK_EN
   logic [12:0] width_r;
   logic [12:0] eff_w;
   logic        err_r;

   assign eff_w      = sof ? image_width : width_r;
   assign error_flag = err_r;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         width_r <= 13'd0;
         err_r   <= 1'b0;
      end else if (take) begin
         if (sof) begin
            width_r <= image_width;
         end
         if ((last_x != (eff_x == (eff_w - 13'd1))) ||
             (sof && (state == CAPTURE) && ((x != 13'd0) || (y != 13'd0)))) begin
            err_r <= 1'b1;
         end
      end
   end
`else
   logic unused_geom;
   assign unused_geom = ^image_width;
   assign error_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_frame_capture.sv
// Randomized bench for frame_capture: a beat-level reference model predicts every write.
module tb_frame_capture;

`ifdef FRAME_CAPTURE_CHECK_EN
   localparam bit CHECK = 1'b1;
`else
   localparam bit CHECK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [12:0] image_width, image_height;
   logic        valid_data_in, sof, last_x;
   logic [7:0]  r, g, b;
   logic        ready_out, mem_ready;
   logic        wr_en;
   logic [31:0] wr_addr, wr_data;
   logic        frame_done, error_flag;
   logic [15:0] frame_count;

   always #5 clk = ~clk;

   frame_capture dut (
      .clk(clk), .reset(reset),
      .image_width(image_width), .image_height(image_height),
      .valid_data_in(valid_data_in), .sof(sof), .last_x(last_x),
      .r(r), .g(g), .b(b),
      .ready_out(ready_out), .mem_ready(mem_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .frame_done(frame_done), .error_flag(error_flag), .frame_count(frame_count)
   );

   int checks = 0;
   int errors = 0;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expv);
      end
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        done;
      logic        err;
      logic [15:0] count;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: tracks the frame as column/row/pixel counts, one call per accepted beat.
   bit          m_active;
   int          m_idx, m_col, m_row, m_w, m_h;
   logic [15:0] m_count;
   bit          m_err;

   function automatic void model_clear();
      m_active = 0; m_idx = 0; m_col = 0; m_row = 0;
      m_w = 0; m_h = 0; m_count = 16'd0; m_err = 0;
      exp_q.delete();
   endfunction

   function automatic void model_beat(bit s, bit lx, logic [7:0] rr, logic [7:0] gg, logic [7:0] bb,
                                      int w, int h);
      exp_t e;
      if (!s && !m_active) return;
      if (s) begin
         if (CHECK && m_active && (m_col != 0 || m_row != 0)) m_err = 1;
         m_active = 1; m_idx = 0; m_col = 0; m_row = 0; m_w = w; m_h = h;
      end
      if (CHECK && (lx != (m_col == m_w - 1))) m_err = 1;
      e.addr = m_idx;
      e.data = {8'h00, rr, gg, bb};
      e.done = 0;
      m_idx++;
      if (lx) begin
         if (m_row == m_h - 1) begin
            e.done = 1;
            m_active = 0;
            m_count = m_count + 16'd1;
         end
         m_row++;
         m_col = 0;
      end else begin
         m_col++;
      end
      e.err   = m_err;
      e.count = m_count;
      exp_q.push_back(e);
   endfunction

   // Memory back-pressure: random stalls plus forced stall windows.
   int stall_prob = 0;
   int stall_hold = 0;
   initial begin
      mem_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (stall_hold > 0) begin
            mem_ready = 1'b0;
            stall_hold--;
         end else begin
            mem_ready = ($urandom_range(0, 99) >= stall_prob);
         end
      end
   end

   // Output monitor on the falling edge.
   logic        prev_wr_en = 1'b0, prev_mem_ready = 1'b1;
   logic [31:0] prev_addr = 32'd0, prev_data = 32'd0;
   initial begin
      exp_t e;
      logic new_write;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_wr_en = 1'b0;
            prev_mem_ready = 1'b1;
         end else begin
            checkOutput("ready_rule", ready_out, mem_ready || !wr_en);
            if (prev_wr_en && !prev_mem_ready) begin
               checkOutput("hold_en", wr_en, 1);
               checkOutput("hold_addr", wr_addr, prev_addr);
               checkOutput("hold_data", wr_data, prev_data);
            end
            new_write = wr_en && (!prev_wr_en || prev_mem_ready);
            if (new_write) begin
               if (exp_q.size() == 0) begin
                  checkOutput("unexpected_write", wr_addr, 32'hFFFF_FFFF);
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("wr_addr", wr_addr, e.addr);
                  checkOutput("wr_data", wr_data, e.data);
                  checkOutput("frame_done", frame_done, e.done);
                  checkOutput("frame_count", frame_count, e.count);
                  checkOutput("error_flag", error_flag, e.err);
               end
            end else begin
               checkOutput("done_quiet", frame_done, 0);
            end
            prev_wr_en = wr_en;
            prev_mem_ready = mem_ready;
            prev_addr = wr_addr;
            prev_data = wr_data;
         end
      end
   end

   task automatic applyStimulus(input bit s, input bit lx, input int w, input int h);
      bit acc = 0;
      int cyc = 0;
      valid_data_in = 1'b1;
      sof = s;
      last_x = lx;
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      image_width  = s ? 13'(w) : 13'($urandom_range(1, 9));
      image_height = s ? 13'(h) : 13'($urandom_range(1, 9));
      while (!acc) begin
         @(negedge clk);
         acc = ready_out;
         @(posedge clk);
         #1;
         cyc++;
         if (!acc && cyc > 60) begin
            checkOutput("accept_timeout", 0, 1);
            break;
         end
      end
      if (acc) model_beat(s, lx, r, g, b, image_width, image_height);
      valid_data_in = 1'b0;
      sof = 1'b0;
      last_x = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input int w, input int h, input bit gaps);
      for (int row = 0; row < h; row++)
         for (int col = 0; col < w; col++) begin
            applyStimulus(row == 0 && col == 0, col == w - 1, w, h);
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         end
   endtask

   task automatic drain();
      stall_prob = 0;
      idle(8);
      checkOutput("queue_empty", exp_q.size(), 0);
   endtask

   task automatic check_reset_values();
      checkOutput("rst_wr_en", wr_en, 0);
      checkOutput("rst_wr_addr", wr_addr, 0);
      checkOutput("rst_wr_data", wr_data, 0);
      checkOutput("rst_frame_done", frame_done, 0);
      checkOutput("rst_error_flag", error_flag, 0);
      checkOutput("rst_frame_count", frame_count, 0);
      checkOutput("rst_ready_out", ready_out, 1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_clear();
      @(negedge clk);
      check_reset_values();
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle(1);
   endtask

   initial begin
      reset = 1'b1;
      valid_data_in = 1'b0; sof = 1'b0; last_x = 1'b0;
      r = 8'd0; g = 8'd0; b = 8'd0;
      image_width = 13'd4; image_height = 13'd2;
      model_clear();
      @(negedge clk);
      check_reset_values();
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle(1);

      // Basic 4x2 frame at full rate.
      send_frame(4, 2, 0);
      drain();
      checkOutput("count_after_first", frame_count, 1);

      // Same frame with a forced three-cycle stall on the write of address 2.
      applyStimulus(1, 0, 4, 2);
      applyStimulus(0, 0, 4, 2);
      applyStimulus(0, 0, 4, 2);
      stall_hold = 3;
      @(negedge clk);
      checkOutput("stall_ready", ready_out, 0);
      checkOutput("stall_addr", wr_addr, 2);
      @(posedge clk);
      #1;
      applyStimulus(0, 1, 4, 2);
      for (int i = 0; i < 4; i++) applyStimulus(0, i == 3, 4, 2);
      drain();

      // Stray beats in IDLE, then a 4x1 frame.
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 4, 1);
      send_frame(4, 1, 0);
      drain();
      checkOutput("count_idle_test", frame_count, 3);

      // sof arriving at pixel 2 of row 0 restarts the frame.
      applyStimulus(1, 0, 4, 2);
      applyStimulus(0, 0, 4, 2);
      applyStimulus(1, 0, 4, 2);
      applyStimulus(0, 0, 4, 2);
      applyStimulus(0, 0, 4, 2);
      applyStimulus(0, 1, 4, 2);
      for (int i = 0; i < 4; i++) applyStimulus(0, i == 3, 4, 2);
      drain();
      checkOutput("err_sof_restart", error_flag, CHECK);

      // Early last_x at x=2 closes row 0 after three pixels.
      do_reset();
      applyStimulus(1, 0, 4, 2);
      applyStimulus(0, 0, 4, 2);
      applyStimulus(0, 1, 4, 2);
      for (int i = 0; i < 4; i++) applyStimulus(0, i == 3, 4, 2);
      drain();
      checkOutput("err_early_lastx", error_flag, CHECK);
      checkOutput("count_early_lastx", frame_count, 1);

      // Reset after five beats abandons the frame; the next sof starts clean.
      do_reset();
      for (int i = 0; i < 5; i++) applyStimulus(i == 0, i == 3, 4, 2);
      do_reset();
      send_frame(4, 2, 0);
      drain();
      checkOutput("count_after_reset", frame_count, 1);

      // Randomized frames under random back-pressure with occasional protocol glitches.
      stall_prob = 30;
      for (int f = 0; f < 30; f++) begin
         int w, h;
         w = $urandom_range(1, 6);
         h = $urandom_range(1, 3);
         if ($urandom_range(0, 4) == 0) begin
            for (int i = 0; i < w * h; i++)
               applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, w, h);
         end else begin
            send_frame(w, h, 1);
         end
         if (f == 15) begin
            drain();
            do_reset();
            stall_prob = 30;
         end
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: simulation did not complete");
      $fatal(1, "[TB] timeout");
   end

endmodule
